// File: rtl/pll_pkg.sv
// Shared types, defaults and saturating arithmetic for the PLL loop filter.
package pll_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } dir_t;

  localparam int DEF_W           = 16;
  localparam int DEF_N           = 8;
  localparam int DEF_KP          = 4;
  localparam int DEF_KI          = 1;
  localparam int DEF_LOCK_CYCLES = 256;

  // Adds in 33 bits and clamps to the signed range of a w-bit word (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) return hi[31:0];
    if (sum < lo) return lo[31:0];
    return sum[31:0];
  endfunction

endpackage

// File: rtl/random_walk.sv
// Random-walk counter: N net steps in one direction emit a single inc/dec pulse.
module random_walk
  import pll_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  dir_t dir_i,
  output logic inc_o,
  output logic dec_o
);

  localparam int WW = $clog2(N) + 2;
  localparam logic signed [WW-1:0] WALK_MAX = WW'(N - 1);
  localparam logic signed [WW-1:0] WALK_MIN = -WALK_MAX;
  localparam logic signed [WW-1:0] ONE      = WW'(1);

  logic signed [WW-1:0] walk_q, walk_d;

  // Clear masks the pulses so a coincident overflow never reaches the integrator.
  always_comb begin
    walk_d = walk_q;
    inc_o  = 1'b0;
    dec_o  = 1'b0;
    case (dir_i)
      UP: begin
        if (walk_q == WALK_MAX) begin
          walk_d = '0;
          inc_o  = !clear_i;
        end else begin
          walk_d = walk_q + ONE;
        end
      end
      DN: begin
        if (walk_q == WALK_MIN) begin
          walk_d = '0;
          dec_o  = !clear_i;
        end else begin
          walk_d = walk_q - ONE;
        end
      end
      default: walk_d = walk_q;
    endcase
    if (clear_i) walk_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) walk_q <= '0;
    else         walk_q <= walk_d;
  end

endmodule

// File: rtl/pd_loop_filter.sv
// PLL loop filter: phase-detector events -> random walk -> saturating integrator
// plus proportional term, giving a signed control word and a lock flag.
module pd_loop_filter
  import pll_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int N           = DEF_N,
  parameter int KP          = DEF_KP,
  parameter int KI          = DEF_KI,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                forwarding_i,
  input  logic                slowing_i,
  input  logic                clear_i,
  output logic signed [W-1:0] ctrl_o,
  output logic                ctrl_valid_o,
  output logic                lock_o
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]        LOCK_MAX = LCW'(LOCK_CYCLES);
  localparam logic signed [W-1:0]   KP_W     = W'(KP);

  dir_t                dir_q, dir_d;
  logic signed [W-1:0] integ_q, integ_d;
  logic signed [W-1:0] prop_q, prop_d;
  logic signed [W-1:0] ctrl_q, ctrl_d;
  logic                vld_q, vld_d;
  logic                lock_q, lock_d;
  logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
  logic                inc, dec, event_hit;

  random_walk #(.N(N)) u_walk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .dir_i   (dir_q),
    .inc_o   (inc),
    .dec_o   (dec)
  );

  // Stage 0: direction decode
  always_comb begin
    dir_d = HOLD;
    if (!clear_i) begin
      if (forwarding_i && !slowing_i)      dir_d = UP;
      else if (slowing_i && !forwarding_i) dir_d = DN;
    end
  end

  // Stage 1: integrator and proportional term, both driven from dir_q
  always_comb begin
    integ_d = integ_q;
    if (inc)      integ_d = W'(sat_add(32'(integ_q), KI, W));
    else if (dec) integ_d = W'(sat_add(32'(integ_q), -KI, W));
    prop_d = '0;
    case (dir_q)
      UP:      prop_d = KP_W;
      DN:      prop_d = -KP_W;
      default: prop_d = '0;
    endcase
    if (clear_i) begin
      integ_d = '0;
      prop_d  = '0;
    end
  end

  // Stage 2: saturated output, change-valid and lock tracking
  always_comb begin
    ctrl_d    = clear_i ? '0 : W'(sat_add(32'(integ_q), 32'(prop_q), W));
    vld_d     = (ctrl_d != ctrl_q);
    event_hit = clear_i || inc || dec;
    if (event_hit)                  lock_cnt_d = '0;
    else if (lock_cnt_q == LOCK_MAX) lock_cnt_d = lock_cnt_q;
    else                             lock_cnt_d = lock_cnt_q + LCW'(1);
    lock_d = !event_hit && (lock_cnt_q == LOCK_MAX);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dir_q      <= HOLD;
      integ_q    <= '0;
      prop_q     <= '0;
      ctrl_q     <= '0;
      vld_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      dir_q      <= dir_d;
      integ_q    <= integ_d;
      prop_q     <= prop_d;
      ctrl_q     <= ctrl_d;
      vld_q      <= vld_d;
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign ctrl_o       = ctrl_q;
  assign ctrl_valid_o = vld_q;
  assign lock_o       = lock_q;

endmodule

// File: tb/tb_pd_loop_filter.sv
// Directed bench for pd_loop_filter: default instance plus an 8-bit KI=64 instance.
module tb_pd_loop_filter;

  logic               clk, reset;
  logic               fwd, slow, clr, vld, lock;
  logic signed [15:0] ctrl;
  logic               fwd_s, slow_s, clr_s, vld_s, lock_s;
  logic signed [7:0]  ctrl_s;

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_c[11];
  int   exp_v[11];
  logic bad;

  pd_loop_filter dut (
    .clk_i(clk), .reset_i(reset), .forwarding_i(fwd), .slowing_i(slow),
    .clear_i(clr), .ctrl_o(ctrl), .ctrl_valid_o(vld), .lock_o(lock)
  );

  pd_loop_filter #(.W(8), .KI(64)) dut_s (
    .clk_i(clk), .reset_i(reset), .forwarding_i(fwd_s), .slowing_i(slow_s),
    .clear_i(clr_s), .ctrl_o(ctrl_s), .ctrl_valid_o(vld_s), .lock_o(lock_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; fwd = 1'b0; slow = 1'b0; clr = 1'b0;
    fwd_s = 1'b0; slow_s = 1'b0; clr_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", ctrl, 0);
    chk("rst_vld", vld, 0);
    chk("rst_lock", lock, 0);
    reset = 1'b0;

    // Idle after reset: silent output, lock after LOCK_CYCLES+1 edges
    bad = 1'b0;
    for (int n = 1; n <= 257; n++) begin
      tick();
      if (vld !== 1'b0 || ctrl !== 16'sd0) bad = 1'b1;
      if (n == 256) chk("idle_lock_pre", lock, 0);
      if (n == 257) chk("idle_lock_rise", lock, 1);
    end
    chk("idle_quiet", bad, 0);

    // Forwarding for 8 samples
    exp_c = '{0, 0, 4, 4, 4, 4, 4, 4, 4, 5, 1};
    exp_v = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    fwd = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 7) fwd = 1'b0;
      chk($sformatf("fwd_ctrl_E%0d", k), ctrl, exp_c[k]);
      chk($sformatf("fwd_vld_E%0d", k), vld, exp_v[k]);
      if (k == 7) chk("fwd_lock_held", lock, 1);
      if (k == 8) chk("fwd_lock_drop", lock, 0);
    end
    tick();
    chk("fwd_vld_E11", vld, 0);

    // Clear from nonzero output
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ctrl", ctrl, 0);
    chk("clr_vld", vld, 1);
    chk("clr_lock", lock, 0);

    // Slowing for 8 samples
    exp_c = '{0, 0, -4, -4, -4, -4, -4, -4, -4, -5, -1};
    slow = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 7) slow = 1'b0;
      chk($sformatf("slow_ctrl_E%0d", k), ctrl, exp_c[k]);
      chk($sformatf("slow_vld_E%0d", k), vld, exp_v[k]);
    end
    tick();
    chk("slow_vld_E11", vld, 0);

    // Both inputs high: HOLD, lock keeps counting from the dec at E8
    fwd = 1'b1; slow = 1'b1;
    bad = 1'b0;
    for (int n = 4; n <= 103; n++) begin
      tick();
      if (ctrl !== -16'sd1 || vld !== 1'b0) bad = 1'b1;
    end
    chk("both_quiet", bad, 0);
    fwd = 1'b0; slow = 1'b0;
    for (int n = 104; n <= 257; n++) begin
      tick();
      if (n == 256) chk("both_lock_pre", lock, 0);
      if (n == 257) chk("both_lock_rise", lock, 1);
    end

    // Walk position survives 100 both-high cycles: 3 UP + 5 UP -> one inc
    clr = 1'b1; tick(); clr = 1'b0;
    fwd = 1'b1;
    repeat (3) tick();
    slow = 1'b1;
    repeat (100) tick();
    slow = 1'b0;
    repeat (5) tick();
    fwd = 1'b0;
    repeat (4) tick();
    chk("walk_hold_ctrl", ctrl, 1);
    chk("walk_hold_lock", lock, 0);

    // Clear mid-walk restarts the walk from zero
    clr = 1'b1; tick(); clr = 1'b0;
    fwd = 1'b1;
    repeat (5) tick();
    chk("mid_pre_ctrl", ctrl, 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("mid_clr_ctrl", ctrl, 0);
    chk("mid_clr_vld", vld, 1);
    chk("mid_clr_lock", lock, 0);
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 7) fwd = 1'b0;
      if (k == 8) chk("mid_F8_ctrl", ctrl, 4);
      if (k == 9) chk("mid_F9_ctrl", ctrl, 5);
      if (k == 10) chk("mid_F10_ctrl", ctrl, 1);
    end

    // Clear coincident with inc: integrator stays 0
    clr = 1'b1; tick(); clr = 1'b0;
    fwd = 1'b1;
    repeat (8) tick();
    clr = 1'b1; fwd = 1'b0;
    tick();
    clr = 1'b0;
    chk("coinc_ctrl", ctrl, 0);
    repeat (2) tick();
    chk("coinc_after_ctrl", ctrl, 0);
    chk("coinc_after_vld", vld, 0);

    // Asynchronous reset mid-operation
    fwd = 1'b1;
    repeat (4) tick();
    chk("arst_pre_ctrl", ctrl, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_ctrl", ctrl, 0);
    chk("arst_vld", vld, 0);
    chk("arst_lock", lock, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    fwd = 1'b0;
    repeat (3) tick();
    chk("arst_after_ctrl", ctrl, 0);

    // Saturation on the 8-bit, KI=64 instance
    fwd_s = 1'b1;
    bad = 1'b0;
    for (int k = 0; k <= 26; k++) begin
      tick();
      if (k == 23) fwd_s = 1'b0;
      if (k == 2) begin
        chk("sat_E2_ctrl", ctrl_s, 4);
        chk("sat_E2_vld", vld_s, 1);
      end
      if (k == 8)  chk("sat_E8_ctrl", ctrl_s, 4);
      if (k == 9) begin
        chk("sat_E9_ctrl", ctrl_s, 68);
        chk("sat_E9_vld", vld_s, 1);
      end
      if (k == 16) chk("sat_E16_ctrl", ctrl_s, 68);
      if (k == 17) begin
        chk("sat_E17_ctrl", ctrl_s, 127);
        chk("sat_E17_vld", vld_s, 1);
      end
      if (k >= 18 && (ctrl_s !== 8'sd127 || vld_s !== 1'b0)) bad = 1'b1;
    end
    chk("sat_clamped_quiet", bad, 0);
    slow_s = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 7) slow_s = 1'b0;
      if (k == 2) begin
        chk("desat_S2_ctrl", ctrl_s, 123);
        chk("desat_S2_vld", vld_s, 1);
      end
      if (k == 8)  chk("desat_S8_ctrl", ctrl_s, 123);
      if (k == 9)  chk("desat_S9_ctrl", ctrl_s, 59);
      if (k == 10) chk("desat_S10_ctrl", ctrl_s, 63);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pd_loop_filter.md
# pd_loop_filter

Digital loop filter for the PLL, directly downstream of `PhaseDetector`. It consumes the detector's forwarding/slowing indications and filters them through a random-walk counter and a saturating integrator. It produces a signed frequency-control word for the NCO/DCO stage, plus a lock indication.

## Interface
- `W`, 16: width of the signed control word and the integrator.
- `N`, 8: random-walk threshold; N net steps in one direction produce one integrator step.
- `KP`, 4: proportional term magnitude; must be < 2^(W-2).
- `KI`, 1: integrator step per walk overflow; must be < 2^(W-2).
- `LOCK_CYCLES`, 256: number of consecutive event-free cycles required before lock is declared.

Ports:
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `forwarding_i`  in  1  from `PhaseDetector.forwarding_o`, synchronous to `clk_i`.
- `slowing_i`  in  1  from `PhaseDetector.slowing_o`, synchronous to `clk_i`.
- `clear_i`  in  1  synchronous clear of all filter state.
- `ctrl_o`  out  W  signed control word (integrator plus proportional term, saturated).
- `ctrl_valid_o`  out  1  one-cycle pulse whenever `ctrl_o` changes value.
- `lock_o`  out  1  high after `LOCK_CYCLES` consecutive cycles with no walk overflow.

## Operation
- **Direction decode**, registered as `dir_q`:
  - UP when forwarding=1 and slowing=0.
  - DN when slowing=1 and forwarding=0.
  - HOLD when both inputs are equal.
- **Random-walk counter** `walk` (signed, width clog2(N)+2):
  - UP: if walk==N-1, set walk←0 and raise `inc`; else walk+1.
  - DN: if walk==-(N-1), set walk←0 and raise `dec`; else walk-1.
  - HOLD: no change.
  - `inc` and `dec` are mutually exclusive by construction.
- **Integrator** `integ` (signed W):
  - `inc` adds KI; `dec` subtracts KI.
  - Saturates at 2^(W-1)-1 and -2^(W-1); it never wraps.
- **Proportional term** `prop_q`: +KP for UP, -KP for DN, 0 for HOLD. It is registered on the same edge as `walk` and `integ`.
- **Output**: `ctrl_o` ← sat_W(integ + prop_q). Compute the sum in W+1 bits, then clamp to the W-bit range.
- **Valid**: `ctrl_valid_o` = 1 for one cycle on the edge where the new `ctrl_o` differs from the old one.
- **Lock**:
  - `lock_cnt` increments each cycle in which neither `inc` nor `dec` is raised, and saturates at LOCK_CYCLES.
  - Any `inc`/`dec` resets `lock_cnt` to 0 and forces `lock_o` to 0.
  - `lock_o` = (lock_cnt == LOCK_CYCLES), registered.
- **Clear**: `clear_i`=1 zeroes dir_q, walk, integ, prop_q, lock_cnt, ctrl_o and lock_o on the next edge.
  - Clear wins over a simultaneous inc/dec.
  - `ctrl_valid_o` pulses if `ctrl_o` was nonzero.
- **Reset values**: every register is 0; in particular `ctrl_o`=0, `ctrl_valid_o`=0 and `lock_o`=0.

## Timing
- Inputs sampled at edge E0 land in `dir_q` at E0.
- `walk`, `integ` and `prop_q` update at E1.
- `ctrl_o` and `ctrl_valid_o` update at E2, giving a latency of 2 cycles from input to output.
- `lock_o` updates one edge after the `lock_cnt` update.
- Reset asserted mid-operation clears all state immediately. Filtering restarts from 0 on the first edge after deassertion.

## Structure
- A shared package `pll_pkg` holds:
  - the `dir_t` enum {HOLD, UP, DN};
  - a saturating-add function `sat_add(a, b, W)`;
  - default values for W, N, KP, KI and LOCK_CYCLES.
- One sub-module, `random_walk`, contains the walk counter and produces the `inc`/`dec` pulses. The integrator, output stage and lock logic stay in the top level.

## Test plan
- **Reset and idle.** Reset, then inputs 0 → `ctrl_o`=0 and `ctrl_valid_o` never pulses. `lock_o` rises exactly LOCK_CYCLES+1 edges after reset release.
- **Forwarding held 8 cycles (defaults).** `ctrl_o`=4 from E2 to E8, 5 at E9, 1 at E10. `ctrl_valid_o` pulses at E2, E9 and E10. `lock_o` drops after the `inc`.
- **Slowing held 8 cycles.** Mirror of the previous case: `ctrl_o` goes -4, then -5, then -1.
- **Both inputs held high for 100 cycles.** No change to `ctrl_o`, `walk` or lock progress; `lock_cnt` keeps counting.
- **Saturation** (W=8, KI=64, forwarding held continuously):
  - `integ` goes 64, then 127 (clamped).
  - `ctrl_o` clamps at 127 and `ctrl_valid_o` stops pulsing.
  - Slowing then brings `integ` back to 63.
- **Clear mid-walk.** After 5 UP cycles, pulse `clear_i` → all outputs are 0 next edge. The next `inc` requires a full 8 further UP cycles. Assert `clear_i` coincident with an `inc` → `integ` stays 0.
